// File: rtl/fetch_queue.sv
// Instruction fetch front-end: single-outstanding imem requests, {instr, pc4} FIFO, redirect flush.
// Define FETCHQ_STATS_EN to build the saturating starve_cnt counter; otherwise starve_cnt is tied to 0.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_order,
  output logic [31:0] if_pc4,
  output logic [31:0] starve_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      stale_q, stale_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_after_pop;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [31:0]      pc4_q   [DEPTH];
  logic [31:0]      pc4_d   [DEPTH];
  logic             pop;
  logic             push;

  assign if_valid  = (count_q != '0);
  assign if_order  = instr_q[rd_ptr_q];
  assign if_pc4    = pc4_q[rd_ptr_q];
  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = (state_q == S_DROP) ? stale_q : fpc_q;

  always_comb begin
    pop             = if_valid && !stall && !redirect;
    push            = 1'b0;
    count_after_pop = count_q - CNT_W'(pop);
    state_d         = state_q;
    fpc_d           = fpc_q;
    stale_d         = stale_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    instr_d         = instr_q;
    pc4_d           = pc4_q;

    unique case (state_q)
      S_IDLE: begin
        if (!redirect && (count_after_pop < FULL)) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          stale_d = fpc_q;
          state_d = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          push    = 1'b1;
          fpc_d   = fpc_q + 32'd4;
          // REQ is only held while this push cannot overflow the next one
          state_d = ((count_after_pop + CNT_W'(1)) < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        // the stale ack completes the abandoned request even if a new redirect lands with it
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      instr_d[wr_ptr_q] = imem_rdata;
      pc4_d[wr_ptr_q]   = fpc_q + 32'd4;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_after_pop + CNT_W'(push);

    if (redirect) begin
      fpc_d    = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      fpc_q    <= RESET_PC;
      stale_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= '{default: '0};
      pc4_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      stale_q  <= stale_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [31:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!if_valid && (starve_q != '1)) starve_d = starve_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign starve_cnt = starve_q;
`else
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed redirect/stats sequences, random run vs queue model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_order;
  logic [31:0] if_pc4;
  logic [31:0] starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit          mem_en  = 1'b1;
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;
  bit          model_en = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_order   (if_order),
    .if_pc4     (if_pc4),
    .starve_cnt (starve_cnt)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Memory: acks a held request after a per-request latency, returning addr ^ KEY
  initial begin : mem_model
    int unsigned wait_c;
    int unsigned lat;
    bit          busy;
    wait_c = 0;
    lat    = 0;
    busy   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin
        if (!busy) begin
          wait_c = 0;
          lat    = $urandom_range(lat_max, lat_min);
        end
        imem_ack   = mem_en && (wait_c >= lat);
        imem_rdata = imem_ack ? word_at(imem_addr) : $urandom;
        busy       = !imem_ack;
        wait_c++;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        busy       = 1'b0;
      end
    end
  end

  // Reference model: queue of fetched addresses, next expected fetch, and one pending stale request
  logic [31:0] mq[$];
  logic [31:0] m_next = RESET_PC;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = '0;
  int          m_gap = 0;
  bit          m_pop;

  always @(negedge clk) begin
    if (model_en) begin
      check("model_valid", 32'(if_valid), 32'(mq.size() > 0));
      if (if_valid && mq.size() > 0) begin
        check("model_pc4", if_pc4, mq[0] + 32'd4);
        check("model_order", if_order, word_at(mq[0]));
      end
      if (imem_req) begin
        if (m_stale) begin
          check("model_stale_addr", imem_addr, m_stale_addr);
        end else begin
          check("model_fetch_addr", imem_addr, m_next);
          check("model_space", 32'(mq.size() < DEPTH), 32'd1);
        end
        m_gap = 0;
      end else if (mq.size() < DEPTH) begin
        m_gap++;
        check("model_req_gap", 32'(m_gap <= 1), 32'd1);
      end
      m_pop = if_valid && !stall && !redirect;
      if (!rst) begin
        mq.delete();
        m_next  = RESET_PC;
        m_stale = 1'b0;
        m_gap   = 0;
      end else if (redirect) begin
        mq.delete();
        m_next       = redirect_pc;
        m_stale      = imem_req && !imem_ack;
        m_stale_addr = imem_addr;
        m_gap        = 0;
      end else begin
        if (m_pop && mq.size() > 0) void'(mq.pop_front());
        if (imem_req && imem_ack) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            mq.push_back(m_next);
            m_next = m_next + 32'd4;
          end
        end
      end
    end
  end

  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          chk;
    bit          rs;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  function automatic vec_t mk(bit rn, bit st, bit chk, bit rs, bit e_req, logic [31:0] e_addr,
                              bit e_valid, logic [31:0] e_pc4);
    vec_t v;
    v.rst_n = rn; v.stall = st; v.redir = 1'b0; v.rpc = '0;
    v.chk = chk; v.rs = rs; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc4 = e_pc4;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          found;
    logic [31:0] first_addr;
    bit          got_first;
    bit          saw_200;

    // Outputs checked at each row reflect the inputs driven by the previous row
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd4, 1, 32'd4));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd8, 1, 32'd8));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd12, 1, 32'd12));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd16, 1, 32'd16));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'd20, 1, 32'd20));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 32'd0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 32'd4, 1, 32'd4));
    tbl.push_back(mk(1, 1, 1, 0, 1, 32'd8, 1, 32'd4));
    tbl.push_back(mk(1, 1, 1, 0, 1, 32'd12, 1, 32'd4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 32'd4));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,     1, 32'd4));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd16, 1, 32'd8));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd20, 1, 32'd12));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd24, 1, 32'd16));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'd28, 1, 32'd20));

    lat_min = 0;
    lat_max = 0;
    foreach (tbl[i]) begin
      step();
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
        if (tbl[i].e_req) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
        check($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
        if (tbl[i].rs) begin
          check($sformatf("tbl%0d_rst_order", i), if_order, 32'd0);
          check($sformatf("tbl%0d_rst_pc4", i), if_pc4, 32'd0);
          check($sformatf("tbl%0d_rst_starve", i), starve_cnt, 32'd0);
        end else if (tbl[i].e_valid) begin
          check($sformatf("tbl%0d_pc4", i), if_pc4, tbl[i].e_pc4);
          check($sformatf("tbl%0d_order", i), if_order, word_at(tbl[i].e_pc4 - 32'd4));
        end
      end
      rst         = tbl[i].rst_n;
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
    end
    stall = 1'b0;

    // Redirect while a 3-cycle request to 0x10 is outstanding
    lat_min = 3;
    lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h10) found = 1'b1;
    end
    check("drop_reach_0x10", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("drop_valid_clear", 32'(if_valid), 32'd0);
    check("drop_req_held", 32'(imem_req), 32'd1);
    check("drop_addr_stale", imem_addr, 32'h10);
    got_first = 1'b0;
    first_addr = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (imem_req && imem_addr != 32'h10 && !got_first) begin
        got_first  = 1'b1;
        first_addr = imem_addr;
      end
      if (if_valid) found = 1'b1;
    end
    check("drop_first_addr", first_addr, 32'h100);
    check("drop_valid_seen", 32'(found), 32'd1);
    check("drop_first_pc4", if_pc4, 32'h104);
    check("drop_first_order", if_order, word_at(32'h100));

    // Redirect coincident with a same-cycle ack and a pop
    lat_min = 0;
    lat_max = 0;
    do_reset();
    repeat (4) step();
    check("coin_pre_req", 32'(imem_req), 32'd1);
    check("coin_pre_valid", 32'(if_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("coin_valid_clear", 32'(if_valid), 32'd0);
    check("coin_idle", 32'(imem_req), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    check("coin_valid_seen", 32'(found), 32'd1);
    check("coin_first_pc4", if_pc4, 32'h44);
    check("coin_first_order", if_order, word_at(32'h40));
    step();
    check("coin_next_pc4", if_pc4, 32'h48);

    // Two redirects while the stale request is still pending
    lat_min = 3;
    lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    check("dbl_reach_0x8", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    check("dbl_addr_stale", imem_addr, 32'h8);
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    got_first = 1'b0;
    first_addr = '0;
    saw_200 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h200) saw_200 = 1'b1;
      if (imem_req && imem_addr != 32'h8 && !got_first) begin
        got_first  = 1'b1;
        first_addr = imem_addr;
      end
      if (if_valid) found = 1'b1;
    end
    check("dbl_first_addr", first_addr, 32'h300);
    check("dbl_no_0x200", 32'(saw_200), 32'd0);
    check("dbl_valid_seen", 32'(found), 32'd1);
    check("dbl_first_pc4", if_pc4, 32'h304);

    // Starvation counter with memory withheld
    mem_en  = 1'b0;
    lat_min = 0;
    lat_max = 0;
    do_reset();
    check("stats_reset", starve_cnt, 32'd0);
    repeat (5) step();
`ifdef FETCHQ_STATS_EN
    check("stats_5_idle", starve_cnt, 32'd5);
`else
    check("stats_tied_0", starve_cnt, 32'd0);
`endif
    check("stats_no_valid", 32'(if_valid), 32'd0);
    mem_en = 1'b1;

    // Random traffic against the queue model
    lat_min = 0;
    lat_max = 3;
    rst = 1'b0;
    step();
    model_en = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rst         = ($urandom_range(199, 0) != 0);
      stall       = ($urandom_range(9, 0) < 3);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF4 : $urandom;
    end
    step();
    model_en = 1'b0;
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
